// File: rtl/icap_reg_access.sv
// ICAP_VIRTEX6 (X32) register-access initiator: sync, type-1 read/write, desync.
// Optional readback timeout is enabled by defining ICAP_TIMEOUT_EN.
module icap_reg_access #(
  parameter int unsigned BIT_SWAP       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        icap_csb,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i,
  input  logic [31:0] icap_o,
  input  logic        icap_busy
);

  localparam logic [31:0] NOOP = 32'h2000_0000;

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_HDR, S_WDATA, S_RD_NOOP,
    S_RD_TURN, S_RD_WAIT, S_RD_BACK, S_DESYNC, S_DONE
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_write;
  logic [4:0]  r_addr;
  logic [31:0] r_wdata;

  logic        w_accept;
  logic [31:0] w_word;
  logic [31:0] w_hdr;
  logic        w_csb;
  logic        w_rdwrb;
  logic        w_rsp;
  logic        w_capture;
  logic        w_timeout;

  // ICAP expects each byte bit-reversed relative to the usual configuration word order.
  function automatic logic [31:0] f_order(input logic [31:0] d);
    logic [31:0] r;
    r = d;
    if (BIT_SWAP != 0) begin
      for (int unsigned b = 0; b < 4; b++) begin
        for (int unsigned k = 0; k < 8; k++) begin
          r[b*8 + k] = d[b*8 + 7 - k];
        end
      end
    end
    return r;
  endfunction

  assign w_accept = req_valid & req_ready;
  assign w_hdr    = (r_write ? 32'h3000_0001 : 32'h2800_0001) | {14'd0, r_addr, 13'd0};

`ifdef ICAP_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] r_tmo;

  always_ff @(posedge clock) begin
    if (reset || w_accept) begin
      r_tmo <= '0;
    end else if (r_state == S_RD_WAIT && !icap_csb && icap_busy) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_RD_WAIT) && !icap_csb && icap_busy &&
                     (r_tmo == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_word      = '0;
    w_csb       = 1'b1;
    w_rdwrb     = 1'b0;
    w_rsp       = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SYNC;
          w_cnt_nxt   = '0;
        end
      end
      S_SYNC: begin
        w_csb = 1'b0;
        case (r_cnt[1:0])
          2'd0:    w_word = 32'hFFFF_FFFF;
          2'd1:    w_word = 32'hAA99_5566;
          default: w_word = NOOP;
        endcase
        if (r_cnt == 4'd3) begin
          w_state_nxt = S_HDR;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_HDR: begin
        w_csb       = 1'b0;
        w_word      = w_hdr;
        w_state_nxt = r_write ? S_WDATA : S_RD_NOOP;
      end
      S_WDATA: begin
        w_csb       = 1'b0;
        w_word      = r_wdata;
        w_state_nxt = S_DESYNC;
      end
      S_RD_NOOP: begin
        w_csb  = 1'b0;
        w_word = NOOP;
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_RD_TURN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_RD_TURN: begin
        w_rdwrb     = 1'b1;
        w_state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        w_csb   = 1'b0;
        w_rdwrb = 1'b1;
        // BUSY is only meaningful once the ICAP has seen CSB low for at least one edge.
        if (!icap_csb && !icap_busy) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RD_BACK;
        end else if (w_timeout) begin
          w_state_nxt = S_RD_BACK;
        end
      end
      S_RD_BACK: begin
        w_state_nxt = S_DESYNC;
      end
      S_DESYNC: begin
        w_csb = 1'b0;
        case (r_cnt[1:0])
          2'd0:    w_word = 32'h3000_8001;
          2'd1:    w_word = 32'h0000_000D;
          default: w_word = NOOP;
        endcase
        if (r_cnt == 4'd3) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_DONE: begin
        w_rsp       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      icap_csb   <= 1'b1;
      icap_rdwrb <= 1'b0;
      icap_i     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      req_ready  <= (w_state_nxt == S_IDLE);
      rsp_valid  <= w_rsp;
      icap_csb   <= w_csb;
      icap_rdwrb <= w_rdwrb;
      icap_i     <= w_csb ? '0 : f_order(w_word);
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        rsp_err <= 1'b0;
      end
      if (w_capture) begin
        rsp_rdata <= f_order(icap_o);
      end
      if (w_timeout) begin
        rsp_rdata <= '1;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icap_reg_access.sv
// Scoreboard bench for icap_reg_access: dut 0 has BIT_SWAP=0, dut 1 has BIT_SWAP=1.
// Each dut has a small ICAP model holding BUSY for a programmable number of read edges.
module tb_icap_reg_access;

  typedef struct {
    logic [31:0] w;
    int          c;
  } wexp_t;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
  } rexp_t;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [4:0]  req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];
  logic        icap_csb   [2];
  logic        icap_rdwrb [2];
  logic [31:0] icap_i     [2];
  logic [31:0] icap_o     [2];
  logic        icap_busy  [2];

  int          hold [2];
  int          mcnt [2];
  logic [31:0] last [2];
  wexp_t       wq   [2][$];
  rexp_t       rq   [2][$];

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  icap_reg_access #(.BIT_SWAP(0), .TIMEOUT_CYCLES(16)) u_dut0 (
    .clock(clk), .reset(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .icap_csb(icap_csb[0]), .icap_rdwrb(icap_rdwrb[0]), .icap_i(icap_i[0]),
    .icap_o(icap_o[0]), .icap_busy(icap_busy[0])
  );

  icap_reg_access #(.BIT_SWAP(1), .TIMEOUT_CYCLES(16)) u_dut1 (
    .clock(clk), .reset(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .icap_csb(icap_csb[1]), .icap_rdwrb(icap_rdwrb[1]), .icap_i(icap_i[1]),
    .icap_o(icap_o[1]), .icap_busy(icap_busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_true(input string tag, input bit cond);
    n_tests++;
    assert (cond) else begin
      n_fail++;
      $error("FAIL %s: observed false expected true", tag);
    end
  endtask

  // Byte-wise bit reversal, written as an index mapping over the whole word.
  function automatic logic [31:0] bswap(input logic [31:0] x, input bit en);
    logic [31:0] y;
    y = x;
    if (en) begin
      for (int i = 0; i < 32; i++) y[i] = x[(i & ~7) | (7 - (i & 7))];
    end
    return y;
  endfunction

  function automatic logic [31:0] sync_w(input int k);
    case (k)
      0:       return 32'hFFFF_FFFF;
      1:       return 32'hAA99_5566;
      default: return 32'h2000_0000;
    endcase
  endfunction

  function automatic logic [31:0] desync_w(input int k);
    case (k)
      0:       return 32'h3000_8001;
      1:       return 32'h0000_000D;
      default: return 32'h2000_0000;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_side
    assign icap_busy[g] = (mcnt[g] < hold[g]);

    always @(posedge clk) begin
      if (!icap_csb[g] && icap_rdwrb[g]) mcnt[g] <= mcnt[g] + 1;
      else                               mcnt[g] <= 0;
    end

    always @(negedge clk) begin
      wexp_t we;
      rexp_t re;
      if (icap_csb[g] === 1'b1) chk("idle_i_zero", icap_i[g], 32'h0);
      if (icap_csb[g] === 1'b0 && icap_rdwrb[g] === 1'b0) begin
        chk_true("word_expected", wq[g].size() != 0);
        if (wq[g].size() != 0) begin
          we = wq[g].pop_front();
          chk("icap_i", icap_i[g], we.w);
          chk("word_cycle", cyc, we.c);
        end
      end
      if (rsp_valid[g] === 1'b1) begin
        chk_true("rsp_expected", rq[g].size() != 0);
        if (rq[g].size() != 0) begin
          re = rq[g].pop_front();
          chk("rsp_rdata", rsp_rdata[g], re.d);
          chk("rsp_err", {31'd0, rsp_err[g]}, {31'd0, re.e});
          chk("rsp_cycle", cyc, re.c);
        end
      end
    end
  end

  task automatic issue(input int d, input bit wr, input logic [4:0] a, input logic [31:0] wd,
                       input int hold_c, input logic [31:0] od, input bit tmo, input bit keep,
                       output int acc);
    int          n;
    int          cw;
    logic [31:0] rd;
    bit          sw;
    sw        = (d == 1);
    hold[d]   = hold_c;
    icap_o[d] = od;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_true("req_ready_wait", req_ready[d] === 1'b1);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    if (!keep) begin
      req_valid[d] = 1'b0;
      req_write[d] = ~wr;
      req_addr[d]  = 5'($urandom);
      req_wdata[d] = $urandom;
    end
    for (int k = 0; k < 4; k++) wq[d].push_back('{bswap(sync_w(k), sw), acc + 1 + k});
    if (wr) begin
      wq[d].push_back('{bswap(32'h3000_0001 | (32'(a) << 13), sw), acc + 5});
      wq[d].push_back('{bswap(wd, sw), acc + 6});
      for (int k = 0; k < 4; k++) wq[d].push_back('{bswap(desync_w(k), sw), acc + 7 + k});
      rq[d].push_back('{last[d], 1'b0, acc + 11});
    end else begin
      wq[d].push_back('{bswap(32'h2800_0001 | (32'(a) << 13), sw), acc + 5});
      wq[d].push_back('{bswap(32'h2000_0000, sw), acc + 6});
      wq[d].push_back('{bswap(32'h2000_0000, sw), acc + 7});
      cw = tmo ? acc + 25 : acc + 10 + hold_c;
      for (int k = 0; k < 4; k++) wq[d].push_back('{bswap(desync_w(k), sw), cw + 2 + k});
      rd = tmo ? 32'hFFFF_FFFF : bswap(od, sw);
      last[d] = rd;
      rq[d].push_back('{rd, tmo, cw + 6});
    end
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while ((wq[d].size() != 0 || rq[d].size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_true("drain", wq[d].size() == 0 && rq[d].size() == 0);
    @(negedge clk);
  endtask

  initial begin
    int a0;
    int a1;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0;
      req_addr[d] = '0; req_wdata[d] = '0; icap_o[d] = '0;
      hold[d] = 0; mcnt[d] = 0; last[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", {31'd0, req_ready[d]}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err[d]}, 32'd0);
      chk("rst_csb", {31'd0, icap_csb[d]}, 32'd1);
      chk("rst_rdwrb", {31'd0, icap_rdwrb[d]}, 32'd0);
      chk("rst_icap_i", icap_i[d], 32'd0);
    end

    // Plain write, no swap.
    issue(0, 1'b1, 5'h01, 32'h1234_5678, 0, 32'h0, 1'b0, 1'b0, a0);
    chk("busy_req_ready", {31'd0, req_ready[0]}, 32'd0);
    wait_idle(0);

    // Read with BUSY held three edges; inspect the turnaround cycle.
    issue(0, 1'b0, 5'h0C, 32'h0, 3, 32'h0424_4093, 1'b0, 1'b0, a0);
    repeat (8) @(negedge clk);
    chk("turn_csb", {31'd0, icap_csb[0]}, 32'd1);
    chk("turn_rdwrb", {31'd0, icap_rdwrb[0]}, 32'd1);
    @(negedge clk);
    chk("wait_csb", {31'd0, icap_csb[0]}, 32'd0);
    chk("wait_rdwrb", {31'd0, icap_rdwrb[0]}, 32'd1);
    wait_idle(0);

    // Swapped instance: write then immediate read.
    issue(1, 1'b1, 5'h05, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 1'b0, a1);
    wait_idle(1);
    issue(1, 1'b0, 5'h1F, 32'h0, 0, 32'h0102_0408, 1'b0, 1'b0, a1);
    wait_idle(1);

    // req_valid held across a write: second accept waits for IDLE.
    issue(0, 1'b1, 5'h02, 32'hA5A5_0001, 0, 32'h0, 1'b0, 1'b1, a0);
    issue(0, 1'b1, 5'h03, 32'h5A5A_0002, 0, 32'h0, 1'b0, 1'b0, a1);
    chk("held_accept_cycle", a1, a0 + 12);
    wait_idle(0);

    // Reset in the middle of a read: no desync, no response.
    issue(0, 1'b0, 5'h0A, 32'h0, 2, 32'hCAFE_F00D, 1'b0, 1'b0, a0);
    repeat (4) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("midrst_csb", {31'd0, icap_csb[0]}, 32'd1);
    chk("midrst_req_ready", {31'd0, req_ready[0]}, 32'd1);
    chk("midrst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata[0], 32'd0);
    while (wq[0].size() != 0 && wq[0][wq[0].size() - 1].c > a0 + 4) void'(wq[0].pop_back());
    rq[0].delete();
    last[0] = '0;
    repeat (30) @(negedge clk);
    wait_idle(0);
    issue(0, 1'b1, 5'h04, 32'h0BAD_CAFE, 0, 32'h0, 1'b0, 1'b0, a0);
    wait_idle(0);

`ifdef ICAP_TIMEOUT_EN
    // BUSY stuck: abort after 16 wait edges, then a write clears rsp_err.
    issue(0, 1'b0, 5'h0C, 32'h0, 100000, 32'h1111_1111, 1'b1, 1'b0, a0);
    wait_idle(0);
    issue(0, 1'b1, 5'h01, 32'h0000_00FF, 0, 32'h0, 1'b0, 1'b0, a0);
    wait_idle(0);
`endif

    chk_true("final_word_q_empty", wq[0].size() == 0 && wq[1].size() == 0);
    chk_true("final_rsp_q_empty", rq[0].size() == 0 && rq[1].size() == 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
